// File: rtl/tdm_demux_4.sv
// Receive side of the 4:1 TDM link: aligns on frame_sync and de-interleaves
// successive valid samples into four per-channel registers.
module tdm_demux_4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [4*WIDTH-1:0]   y,
  output logic [3:0]           ch_strobe,
  output logic                 frame_done,
  output logic                 locked,
  output logic                 sync_err,
  output logic [1:0]           slot
);

  localparam int unsigned NUM_CH = 4;

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [4*WIDTH-1:0] y_q, y_d;
  logic [3:0]         strobe_q, strobe_d;
  logic               frame_done_q, frame_done_d;
  logic               sync_err_q, sync_err_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      y_q          <= '0;
      strobe_q     <= 4'd0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      y_q          <= y_d;
      strobe_q     <= strobe_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Next state, slot pointer and channel writes
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    y_d          = y_q;
    strobe_d     = 4'd0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            y_d[0 +: WIDTH] = din;
            strobe_d        = 4'b0001;
            slot_d          = 2'd1;
            state_d         = LOCKED;
          end
        end
        default: begin
          if (frame_sync && (slot_q != 2'd0)) begin
            // Sync seen mid-frame: restart at slot 0, earlier channels keep their values
            y_d[0 +: WIDTH] = din;
            strobe_d        = 4'b0001;
            slot_d          = 2'd1;
            sync_err_d      = 1'b1;
          end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
              if (slot_q == 2'(i)) y_d[i*WIDTH +: WIDTH] = din;
            end
            strobe_d     = 4'b0001 << slot_q;
            frame_done_d = (slot_q == 2'd3);
            slot_d       = slot_q + 2'd1;
          end
        end
      endcase
    end
  end

  assign y          = y_q;
  assign ch_strobe  = strobe_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCKED);
  assign slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Self-checking bench for tdm_demux_4: one WIDTH=1 and one WIDTH=8 instance
// against a frame-level reference model, directed cases then random traffic.
module tb_tdm_demux_4;

  logic clk;
  logic rst_n;

  logic       din1, v1, fs1;
  logic [3:0] y1, stb1;
  logic       fd1, lk1, se1;
  logic [1:0] sl1;

  logic [7:0]  din8;
  logic        v8, fs8;
  logic [31:0] y8;
  logic [3:0]  stb8;
  logic        fd8, lk8, se8;
  logic [1:0]  sl8;

  tdm_demux_4 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(v1), .frame_sync(fs1),
    .y(y1), .ch_strobe(stb1), .frame_done(fd1), .locked(lk1), .sync_err(se1), .slot(sl1)
  );

  tdm_demux_4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .din_valid(v8), .frame_sync(fs8),
    .y(y8), .ch_strobe(stb8), .frame_done(fd8), .locked(lk8), .sync_err(se8), .slot(sl8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model, one entry per instance (0: WIDTH=1, 1: WIDTH=8)
  int         m_y[2][4];
  bit         m_lk[2];
  int         m_slot[2];
  logic [3:0] e_stb[2];
  bit         e_fd[2];
  bit         e_se[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lk[k] = 0; m_slot[k] = 0; e_stb[k] = 4'd0; e_fd[k] = 0; e_se[k] = 0;
      for (int i = 0; i < 4; i++) m_y[k][i] = 0;
    end
  endtask

  task automatic model(input int k, input int d, input bit v, input bit fs);
    int dm;
    dm = (k == 0) ? (d & 1) : (d & 255);
    e_stb[k] = 4'd0; e_fd[k] = 0; e_se[k] = 0;
    if (v) begin
      if (!m_lk[k]) begin
        if (fs) begin
          m_y[k][0] = dm; e_stb[k] = 4'd1; m_slot[k] = 1; m_lk[k] = 1;
        end
      end else if (fs && m_slot[k] != 0) begin
        m_y[k][0] = dm; e_stb[k] = 4'd1; m_slot[k] = 1; e_se[k] = 1;
      end else begin
        m_y[k][m_slot[k]] = dm;
        e_stb[k] = 4'(1 << m_slot[k]);
        e_fd[k] = (m_slot[k] == 3);
        m_slot[k] = (m_slot[k] + 1) % 4;
      end
    end
  endtask

  function automatic logic [31:0] exp_y(input int k);
    logic [31:0] r;
    int w;
    w = (k == 0) ? 1 : 8;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r = r | (32'(m_y[k][i]) << (i * w));
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    check("w1_y",      32'(y1),   exp_y(0));
    check("w1_strobe", 32'(stb1), 32'(e_stb[0]));
    check("w1_fdone",  32'(fd1),  32'(e_fd[0]));
    check("w1_serr",   32'(se1),  32'(e_se[0]));
    check("w1_locked", 32'(lk1),  32'(m_lk[0]));
    check("w1_slot",   32'(sl1),  32'(m_slot[0]));
    check("w8_y",      y8,        exp_y(1));
    check("w8_strobe", 32'(stb8), 32'(e_stb[1]));
    check("w8_fdone",  32'(fd8),  32'(e_fd[1]));
    check("w8_serr",   32'(se8),  32'(e_se[1]));
    check("w8_locked", 32'(lk8),  32'(m_lk[1]));
    check("w8_slot",   32'(sl8),  32'(m_slot[1]));
  endtask

  // Drive one cycle on instance k (other instance idle), then check both
  task automatic step(input int k, input int d, input bit v, input bit fs);
    if (k == 0) begin
      din1 = 1'(d); v1 = v; fs1 = fs; v8 = 1'b0; fs8 = 1'b0;
    end else begin
      din8 = 8'(d); v8 = v; fs8 = fs; v1 = 1'b0; fs1 = 1'b0;
    end
    model(k, d, v, fs);
    model(1 - k, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    v1 = 1'b0; fs1 = 1'b0; v8 = 1'b0; fs8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    din1 = 1'b0; v1 = 1'b0; fs1 = 1'b0;
    din8 = 8'd0; v8 = 1'b0; fs8 = 1'b0;
    model_reset();
    #3;
    check_all();
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 0,1,0,1
    step(0, 0, 1, 1); check("t1_stb0", 32'(stb1), 32'h1);
    step(0, 1, 1, 0); check("t1_stb1", 32'(stb1), 32'h2);
    step(0, 0, 1, 0); check("t1_stb2", 32'(stb1), 32'h4);
    step(0, 1, 1, 0); check("t1_stb3", 32'(stb1), 32'h8);
    check("t1_y", 32'(y1), 32'hA);
    check("t1_fd", 32'(fd1), 32'h1);

    // HUNT drops unsynced samples
    async_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    check("t2_y_hunt", 32'(y1), 32'h0);
    check("t2_lk_hunt", 32'(lk1), 32'h0);
    step(0, 1, 1, 1);
    check("t2_lk", 32'(lk1), 32'h1);
    check("t2_slot", 32'(sl1), 32'h1);

    // Early sync mid-frame re-aligns
    step(0, 0, 1, 0);
    step(0, 1, 1, 1);
    check("t3_serr", 32'(se1), 32'h1);
    check("t3_fd", 32'(fd1), 32'h0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    check("t3_fd_end", 32'(fd1), 32'h1);

    // Gapped frame with a sync pulse during a gap
    for (int s = 0; s < 4; s++) begin
      step(0, s % 2, 1, s == 0);
      for (int g = 0; g < 5; g++) step(0, 0, 0, (s == 2 && g == 2));
    end
    check("t4_y", 32'(y1), 32'hA);

    // Async reset after slot 2, then unsynced sample is dropped
    step(0, 1, 1, 1);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    async_reset();
    check("t5_y_rst", 32'(y1), 32'h0);
    step(0, 1, 1, 0);
    check("t5_lk", 32'(lk1), 32'h0);

    // WIDTH=8 frame and back-to-back frames
    step(1, 8'hA5, 1, 1);
    step(1, 8'h3C, 1, 0);
    step(1, 8'hFF, 1, 0);
    step(1, 8'h00, 1, 0);
    check("t6_y", y8, 32'h00FF3CA5);
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 4; s++) step(1, int'($urandom_range(0, 255)), 1, s == 0);

    // Random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      if (i == 300) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
